operand_issue: RTL

OPERAND_ISSUE -- requirements
Module: operand_issue

---
 rtl/proc_pkg.sv | 26 ++
 rtl/operand_issue_if.sv | 28 ++
 rtl/issue_scoreboard.sv | 39 +++
 rtl/operand_issue.sv | 118 +++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types and encodings for the operand issue stage.
package proc_pkg;
  localparam int REG_W    = 4;
  localparam int NUM_REGS = 1 << REG_W;
  localparam int DATA_W   = 32;

  localparam logic [1:0] SEL_DEC = 2'b00;
  localparam logic [1:0] SEL_FWD = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    IDLE, ISSUE, STALL_LU, STALL_MEM, STALL_SB
  } state_e;

  typedef struct packed {
    reg_idx_t rd;
    logic     rd_wr;
    logic     is_load;
  } stage_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t r);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
  endfunction
endpackage

// File: rtl/operand_issue_if.sv
// Decoder -> issue handshake bundle.
interface operand_issue_if;
  import proc_pkg::*;

  logic              dec_valid;
  logic              dec_ready;
  logic [DATA_W-1:0] dec_operand0;
  logic [DATA_W-1:0] dec_operand1;
  reg_idx_t          dec_rs0;
  reg_idx_t          dec_rs1;
  reg_idx_t          dec_rd;
  logic              dec_rd_wr;
  logic              dec_is_load;
  logic [3:0]        dec_operation;
  logic [3:0]        dec_ctrl;

  modport master (
    output dec_valid, dec_operand0, dec_operand1, dec_rs0, dec_rs1, dec_rd,
           dec_rd_wr, dec_is_load, dec_operation, dec_ctrl,
    input  dec_ready
  );

  modport slave (
    input  dec_valid, dec_operand0, dec_operand1, dec_rs0, dec_rs1, dec_rd,
           dec_rd_wr, dec_is_load, dec_operation, dec_ctrl,
    output dec_ready
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Pending-write mask plus the E/M stage trackers for hazard detection.
module issue_scoreboard import proc_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                advance,
  input  logic                issue,
  input  stage_t              issue_ent,
  input  logic                wb_valid,
  input  reg_idx_t            wb_rd,
  output logic [NUM_REGS-1:0] mask,
  output stage_t              stage_e,
  output stage_t              stage_m
);
  logic [NUM_REGS-1:0] set_v, clr_v, mask_nxt;

  assign set_v = (issue && issue_ent.rd_wr) ? reg_onehot(issue_ent.rd) : '0;
  assign clr_v = wb_valid ? reg_onehot(wb_rd) : '0;

  // A new write to a register outranks a retirement of the same register.
  for (genvar g = 0; g < NUM_REGS; g++) begin : gen_mask
    assign mask_nxt[g] = set_v[g] | (mask[g] & ~clr_v[g]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  mask <= '0;
    else if (en) mask <= mask_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_e <= '0;
      stage_m <= '0;
    end else if (en && advance) begin
      stage_m <= stage_e;
      stage_e <= issue ? issue_ent : '0;
    end
  end
endmodule

// File: rtl/operand_issue.sv
// Operand issue stage: hazard check against the scoreboard, registered ALU issue.
// Define OPERAND_ISSUE_FWD_EN to enable ALU-result and load-data forwarding on operand1.
module operand_issue import proc_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  operand_issue_if.slave    dec,
  input  logic              wb_valid,
  input  reg_idx_t          wb_rd,
  input  logic              mem_data_valid,
  input  logic              alu_ready,
  output logic [DATA_W-1:0] operand0,
  output logic [DATA_W-1:0] operand1,
  output logic [3:0]        operation,
  output logic [3:0]        alu_ctrl,
  output logic [1:0]        sel,
  output logic              NOP
);
  state_e              state, state_nxt;
  logic                issue_ok, mem_wait, accept;
  logic [1:0]          sel_nxt;
  logic [NUM_REGS-1:0] mask;
  stage_t              stage_e, stage_m, dec_ent;
  logic                rs0_pend, rs1_pend;

  assign dec_ent = {dec.dec_rd, dec.dec_rd_wr, dec.dec_is_load};

  // Waiting on load data freezes E/M so the load stays visible in M.
  issue_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (alu_ready),
    .advance   (~mem_wait),
    .issue     (accept),
    .issue_ent (dec_ent),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .mask      (mask),
    .stage_e   (stage_e),
    .stage_m   (stage_m)
  );

  assign rs0_pend = mask[dec.dec_rs0];
  assign rs1_pend = mask[dec.dec_rs1];

`ifdef OPERAND_ISSUE_FWD_EN
  logic e_hit, m_hit;
  assign e_hit = stage_e.rd_wr && (stage_e.rd == dec.dec_rs1);
  assign m_hit = stage_m.rd_wr && stage_m.is_load && (stage_m.rd == dec.dec_rs1);
`else
  logic unused_fwd;
  assign unused_fwd = ^{mem_data_valid, stage_e, stage_m};
`endif

  always_comb begin
    state_nxt = IDLE;
    issue_ok  = 1'b0;
    sel_nxt   = SEL_DEC;
    mem_wait  = 1'b0;
    if (!dec.dec_valid) begin
      state_nxt = IDLE;
    end else if (rs0_pend) begin
      state_nxt = STALL_SB;
    end else if (!rs1_pend) begin
      state_nxt = ISSUE;
      issue_ok  = 1'b1;
    end
`ifdef OPERAND_ISSUE_FWD_EN
    else if (e_hit) begin
      if (stage_e.is_load) begin
        state_nxt = STALL_LU;
      end else begin
        state_nxt = ISSUE;
        issue_ok  = 1'b1;
        sel_nxt   = SEL_FWD;
      end
    end else if (m_hit) begin
      if (mem_data_valid) begin
        state_nxt = ISSUE;
        issue_ok  = 1'b1;
        sel_nxt   = SEL_MEM;
      end else begin
        state_nxt = STALL_MEM;
        mem_wait  = 1'b1;
      end
    end
`endif
    else begin
      state_nxt = STALL_SB;
    end
  end

  assign accept        = issue_ok & alu_ready;
  assign dec.dec_ready = accept & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         state <= IDLE;
    else if (alu_ready) state <= state_nxt;
  end

  // Bubbles only drop NOP; the operand registers keep their last issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand0  <= '0;
      operand1  <= '0;
      operation <= '0;
      alu_ctrl  <= '0;
      sel       <= SEL_DEC;
    end else if (accept) begin
      operand0  <= dec.dec_operand0;
      operand1  <= dec.dec_operand1;
      operation <= dec.dec_operation;
      alu_ctrl  <= dec.dec_ctrl;
      sel       <= sel_nxt;
    end
  end

  assign NOP = (state != ISSUE);
endmodule
